mux_arb_nto1: RTL and testbench

Parametrised N-to-1 arbitrated multiplexer with a registered output stage, the next generation of the datapath selector muxes. Instead of an external select, each input channel carries its own valid/ready handshake and an internal arbiter picks the winner. The block sits between multiple 24-bit producers (ALU result, memory read, immediate path, I/O) and a single consumer such as the register-file write port. It buffers one word so that the producers and the consumer are decoupled by one cycle.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/rr_grant.sv | 49 ++++
 rtl/mux_arb_nto1.sv | 88 ++++++++
 tb/tb_mux_arb_nto1.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and helpers for the arbitrated N-to-1 mux.
//   DEF_WIDTH / DEF_N : default data width and channel count
//   sel_w()           : channel-index width, max(1, clog2(n))
//   chan_idx_t        : channel index type for the default channel count
package mux_arb_pkg;

  localparam int unsigned DEF_WIDTH = 24;
  localparam int unsigned DEF_N     = 8;

  // Index width never collapses to zero, so N=2 still gets a 1-bit index.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_SELW = sel_w(DEF_N);

  typedef logic [DEF_SELW-1:0] chan_idx_t;

endpackage : mux_arb_pkg

// File: rtl/rr_grant.sv
// rr_grant: combinational one-hot grant over N requests.
// With MUX_ARB_RR_EN defined, the search starts at ptr and wraps modulo N
// (round-robin); otherwise index 0 has highest priority and there is no ptr port.
//   req     : per-channel request
//   ptr     : round-robin start index (MUX_ARB_RR_EN only)
//   grant_c : one-hot grant, zero when no request
//   idx_c   : encoded index of the granted channel (0 when none)
//   any_c   : at least one request present
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned SELW = sel_w(N)
) (
  input  logic [N-1:0]    req,
`ifdef MUX_ARB_RR_EN
  input  logic [SELW-1:0] ptr,
`endif
  output logic [N-1:0]    grant_c,
  output logic [SELW-1:0] idx_c,
  output logic            any_c
);

  // Walk the channels in search order; the first requester wins.
  always_comb begin
    int unsigned     cand;
    logic [SELW-1:0] ci;
    logic            found;
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
`ifdef MUX_ARB_RR_EN
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
`else
      cand = k;
`endif
      ci = SELW'(cand);
      if (!found && req[ci]) begin
        found       = 1'b1;
        grant_c[ci] = 1'b1;
        idx_c       = ci;
      end
    end
    any_c = found;
  end

endmodule : rr_grant

// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 arbitrated multiplexer with a one-word output register.
// Optional feature macro: MUX_ARB_RR_EN (round-robin; fixed priority otherwise).
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   in_valid  : per-channel request
//   in_data   : channel i at [i*WIDTH +: WIDTH]
//   in_ready  : per-channel accept, one-hot or zero
//   out_valid : output register holds a word
//   out_data  : held word
//   out_sel   : index of the channel that produced out_data
//   out_ready : consumer accepts out_data
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned N     = DEF_N,
  localparam int unsigned SELW  = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [N-1:0]     grant_c;
  logic [SELW-1:0]  grant_idx_c;
  logic             any_c;
  logic             load_en_c;
  logic [WIDTH-1:0] sel_data_c;

`ifdef MUX_ARB_RR_EN
  logic [SELW-1:0]  ptr;
`endif

  rr_grant #(
    .N    (N),
    .SELW (SELW)
  ) u_grant (
    .req     (in_valid),
`ifdef MUX_ARB_RR_EN
    .ptr     (ptr),
`endif
    .grant_c (grant_c),
    .idx_c   (grant_idx_c),
    .any_c   (any_c)
  );

  // Output register is empty or draining this cycle.
  assign load_en_c  = !out_valid || out_ready;

  // Reset blocks acceptance so no producer believes its word was taken.
  assign in_ready   = (load_en_c && !rst) ? grant_c : '0;

  assign sel_data_c = in_data[32'(grant_idx_c)*WIDTH +: WIDTH];

  // Output holding register; data/sel keep their value when the slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en_c) begin
      if (any_c) begin
        out_valid <= 1'b1;
        out_data  <= sel_data_c;
        out_sel   <= grant_idx_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_RR_EN
  // Pointer moves just past the last served channel, wrapping N-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load_en_c && any_c) begin
      ptr <= (32'(grant_idx_c) == N - 1) ? '0 : SELW'(32'(grant_idx_c) + 1);
    end
  end
`endif

endmodule : mux_arb_nto1

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: directed bench for mux_arb_nto1 (N=8 main instance, N=5 wrap instance).
module tb_mux_arb_nto1;

  localparam int unsigned W  = 24;
  localparam int unsigned N  = 8;
  localparam int unsigned N5 = 5;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [2:0]      out_sel;
  logic            out_ready;

  logic            rst5;
  logic [N5-1:0]   in_valid5;
  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]   in_ready5;
  logic            out_valid5;
  logic [W-1:0]    out_data5;
  logic [2:0]      out_sel5;
  logic            out_ready5;

  int n_cmp = 0;
  int n_err = 0;

  mux_arb_nto1 #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  mux_arb_nto1 #(.WIDTH(W), .N(N5)) dut5 (
    .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_data(out_data5),
    .out_sel(out_sel5), .out_ready(out_ready5)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dat(input int i);
    return 24'hC00000 + 24'(i * 24'h000111);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    clk        = 1'b0;
    rst        = 1'b1;
    rst5       = 1'b1;
    out_ready  = 1'b1;
    out_ready5 = 1'b1;
    in_valid   = '1;
    in_valid5  = '0;
    for (int i = 0; i < N; i++)  in_data[i*W +: W]  = dat(i);
    for (int i = 0; i < N5; i++) in_data5[i*W +: W] = dat(i + 16);

    // Reset held 2 cycles with every channel requesting
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_in_ready",  32'(in_ready),  32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data",  32'(out_data),  32'h0);
      check("rst_out_sel",   32'(out_sel),   32'h0);
    end

    // Single channel 2
    rst      = 1'b0;
    in_valid = 8'b0000_0100;
    in_data[2*W +: W] = 24'hA5A5A5;
    #1;
    check("single_in_ready", 32'(in_ready), 32'h04);
    tick();
    check("single_out_valid", 32'(out_valid), 32'h1);
    check("single_out_data",  32'(out_data),  32'hA5A5A5);
    check("single_out_sel",   32'(out_sel),   32'h2);
    in_data[2*W +: W] = dat(2);

    // Fairness: pointer back to 0, then all channels valid for 9 beats
    rst      = 1'b1;
    in_valid = '1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
`ifdef MUX_ARB_RR_EN
      #1;
      check("fair_in_ready", 32'(in_ready), 32'(8'b1 << (k % 8)));
      tick();
      check("fair_out_sel",  32'(out_sel),  32'(k % 8));
      check("fair_out_data", 32'(out_data), 32'(dat(k % 8)));
`else
      #1;
      check("fair_in_ready", 32'(in_ready), 32'h01);
      tick();
      check("fair_out_sel",  32'(out_sel),  32'h0);
      check("fair_out_data", 32'(out_data), 32'(dat(0)));
`endif
    end

    // Drain to empty
    in_valid = '0;
    tick();
    check("drain_out_valid", 32'(out_valid), 32'h0);

    // Backpressure: fill from channels 3/5, then stall 5 cycles
    in_valid  = 8'b0010_1000;
    out_ready = 1'b0;
    #1;
    check("bp_fill_in_ready", 32'(in_ready), 32'h08);
    tick();
    check("bp_fill_sel",  32'(out_sel),  32'h3);
    check("bp_fill_data", 32'(out_data), 32'(dat(3)));
    held     = out_data;
    in_valid = 8'b0010_0000;
    for (int c = 0; c < 5; c++) begin
      check("bp_stall_in_ready", 32'(in_ready),  32'h0);
      tick();
      check("bp_stall_valid",    32'(out_valid), 32'h1);
      check("bp_stall_data",     32'(out_data),  32'(held));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'h20);
    tick();
    check("bp_release_sel",  32'(out_sel),  32'h5);
    check("bp_release_data", 32'(out_data), 32'(dat(5)));
    in_valid = '0;
    tick();
    check("bp_empty_valid", 32'(out_valid), 32'h0);

    // Reset mid-stream with a stalled word
    in_valid  = 8'b0000_0001;
    out_ready = 1'b0;
    tick();
    check("mid_fill_valid", 32'(out_valid), 32'h1);
    check("mid_fill_sel",   32'(out_sel),   32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data",  32'(out_data),  32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 8'b1000_0001;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h01);
    tick();
    check("post_rst_sel", 32'(out_sel), 32'h0);
    in_valid = 8'b1000_0000;
    tick();
    check("post_rst_sel2",  32'(out_sel),  32'h7);
    check("post_rst_data2", 32'(out_data), 32'(dat(7)));
    in_valid = '0;

    // N=5 wrap: serve channel 3 so the pointer lands on 4, then 4 and 0 both valid
    rst5 = 1'b0;
    in_valid5 = 5'b01000;
    #1;
    check("n5_pre_in_ready", 32'(in_ready5), 32'h08);
    tick();
    check("n5_pre_sel", 32'(out_sel5), 32'h3);
    in_valid5 = 5'b10001;
    for (int k = 0; k < 2; k++) begin
`ifdef MUX_ARB_RR_EN
      #1;
      check("n5_wrap_in_ready", 32'(in_ready5), (k == 0) ? 32'h10 : 32'h01);
      tick();
      check("n5_wrap_sel",  32'(out_sel5),  (k == 0) ? 32'h4 : 32'h0);
      check("n5_wrap_data", 32'(out_data5), (k == 0) ? 32'(dat(20)) : 32'(dat(16)));
`else
      #1;
      check("n5_wrap_in_ready", 32'(in_ready5), 32'h01);
      tick();
      check("n5_wrap_sel",  32'(out_sel5),  32'h0);
      check("n5_wrap_data", 32'(out_data5), 32'(dat(16)));
`endif
    end
    in_valid5 = '0;
    tick();
    check("n5_empty_valid", 32'(out_valid5), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_arb_nto1
